proximity_detector: RTL and testbench
=====================================

Name: proximity_detector

Overview:
- Parametrised successor to the two-pair IR distance-sensor front end.
- Synchronises and debounces NUM_SIDES groups of IR distance sensors, then reduces each group to a per-side detect flag using AND or OR mode.
- Emits a single-cycle proximity pulse on a new detection, with a retrigger lockout, the index of the triggering side and a saturating event counter.
- Sits between the raw sensor pins and the station-docking / motor control logic.

Parameters:
- NUM_SIDES, 2, number of sensor groups (sides); must be ≥1.
- SENSORS_PER_SIDE, 2, sensors per group; DIS width = NUM_SIDES*SENSORS_PER_SIDE.
- DEBOUNCE_CYCLES, 16, consecutive cycles a side's raw hit must differ from dist_state before dist_state follows; must be ≥1.
- LOCKOUT_CYCLES, 1000, cycles after a proximity pulse during which new rises are ignored; 0 disables lockout.
- CNT_W, 8, event_count width.
- SIDE_W, max(1,$clog2(NUM_SIDES)), side_id width (derived localparam).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- DIS  in  NUM_SIDES*SENSORS_PER_SIDE  raw sensor levels, asynchronous to clk; side s owns bits [s*SENSORS_PER_SIDE +: SENSORS_PER_SIDE].
- any_mode  in  1  0: a side hits only when all its sensors are high; 1: a side hits when any of its sensors is high. Quasi-static.
- clear_count  in  1  synchronous clear of event_count.
- dist_state  out  NUM_SIDES  debounced per-side detect flags.
- proximity  out  1  one-cycle pulse on an accepted new detection.
- side_id  out  SIDE_W  lowest-index side that caused the last pulse; holds between pulses.
- locked  out  1  high while the lockout counter is non-zero.
- event_count  out  CNT_W  number of accepted pulses, saturating.

Behaviour:
- Reset (async assert, released synchronously to clk by the system): synchroniser flops, debounce counters, dist_state, proximity, side_id, locked, lockout counter and event_count all 0.
- Synchroniser: two-flop synchroniser on every DIS bit; no logic between the stages.
- Raw hit, per side: AND or OR (per any_mode) over that side's synchronised bits.
- Debounce, per side (counter width $clog2(DEBOUNCE_CYCLES+1)):
  - When raw hit equals dist_state[s], the counter clears.
  - Otherwise the counter increments.
  - When the counter reaches DEBOUNCE_CYCLES-1 while still differing, dist_state[s] toggles on that edge and the counter clears.
  - Symmetric for rise and fall. A glitch shorter than DEBOUNCE_CYCLES cycles never reaches dist_state.
- Latency: a stable DIS change first sampled at edge k appears on dist_state at edge k+1+DEBOUNCE_CYCLES.
- Rise detect: rise[s] = dist_state[s] & ~dist_state_d[s], where dist_state_d is a one-cycle delayed copy.
- Pulse acceptance: if any rise[s] and the lockout counter is 0, on the next edge:
  - proximity=1 for exactly one cycle;
  - side_id = lowest s with rise[s];
  - lockout counter loads LOCKOUT_CYCLES;
  - event_count increments.
- Rises while the lockout counter is non-zero are dropped, not queued. side_id and event_count are unchanged.
- Lockout counter decrements to 0 each cycle when non-zero. locked = (counter != 0).
- Simultaneous rises on several sides: one pulse; side_id = lowest index.
- event_count saturates at 2^CNT_W-1; further accepted pulses still produce proximity.
- clear_count clears event_count. If clear_count and an accepted pulse occur in the same cycle, event_count = 1.
- Falling dist_state never produces a pulse.
- Changing any_mode mid-operation only changes the raw hit; debounce applies normally.
- Reset mid-debounce or mid-lockout: all state clears immediately; no pulse is emitted on reset release even if DIS is high, until DIS has passed through sync+debounce again (that rise then does pulse).

Decomposition:
- Package proximity_pkg holds:
  - the default parameter constants;
  - a function for the SIDE_W / counter-width calculation;
  - the mode encoding constants (MODE_ALL=0, MODE_ANY=1).
- One sub-module, side_debouncer: synchroniser, per-side reduce and debounce counter, instantiated in a generate loop NUM_SIDES times.
- Top level holds rise detect, priority encode, lockout and event counter.

Test Plan:
- Bench parameters: DEBOUNCE_CYCLES=4, LOCKOUT_CYCLES=10, CNT_W=4, defaults otherwise.
- Reset, DIS=4'b0000 → all outputs 0. Then DIS=4'b0011 held, any_mode=0 → dist_state=2'b01 five edges after first sample, proximity high one cycle later, side_id=0, event_count=1, locked high 10 cycles.
- Glitch: DIS=4'b1100 for 3 cycles then 0 → dist_state stays 0, no proximity. DIS=4'b0100 held with any_mode=0 → no detect; switch any_mode=1 → dist_state[1]=1, one pulse with side_id=1.
- Simultaneous: DIS 0→4'b1111 in one cycle → single pulse, side_id=0, dist_state=2'b11. During lockout, toggle side 0 off/on (≥5 cycles each) → rise dropped, event_count unchanged, no pulse.
- Saturation and clear: 17 accepted pulses spaced beyond lockout → event_count=15 after the 15th, holds at 15, proximity still pulses. clear_count asserted in the same cycle as an accepted pulse → event_count=1.
- Async reset asserted mid-lockout with DIS=4'b0011 held → outputs 0 immediately. After release, exactly one pulse 6 edges later (2 sync + 4 debounce), event_count=1.

Source files
------------

// File: rtl/proximity_pkg.sv
// Shared constants and helpers for the proximity detector front end.
package proximity_pkg;

   // Default parameter values
   localparam int DEF_NUM_SIDES        = 2;
   localparam int DEF_SENSORS_PER_SIDE = 2;
   localparam int DEF_DEBOUNCE_CYCLES  = 16;
   localparam int DEF_LOCKOUT_CYCLES   = 1000;
   localparam int DEF_CNT_W            = 8;

   // any_mode encoding
   localparam logic MODE_ALL = 1'b0;
   localparam logic MODE_ANY = 1'b1;

   // Bits needed to encode values 0..n-1, never less than one bit.
   function automatic int width_for(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/side_debouncer.sv
// One sensor side: two-flop synchroniser, AND/OR reduce, symmetric debounce.
module side_debouncer
   import proximity_pkg::*;
#(
   parameter int SENSORS         = DEF_SENSORS_PER_SIDE,
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [SENSORS-1:0] i_dis,
   input  logic               i_any_mode,
   output logic               o_dist_state
);

   localparam int              CW   = width_for(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0]   TERM = CW'(DEBOUNCE_CYCLES - 1);

   logic [SENSORS-1:0] r_sync1;
   logic [SENSORS-1:0] r_sync2;
   logic [CW-1:0]      r_cnt;
   logic               r_state;
   logic               w_hit;

   // Plain two-flop synchroniser, nothing between the stages
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
      end else begin
         r_sync1 <= i_dis;
         r_sync2 <= r_sync1;
      end
   end

   assign w_hit = (i_any_mode == MODE_ANY) ? |r_sync2 : &r_sync2;

   // Follow the raw hit only after it has differed for DEBOUNCE_CYCLES edges
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt   <= '0;
         r_state <= 1'b0;
      end else if (w_hit == r_state) begin
         r_cnt <= '0;
      end else if (r_cnt == TERM) begin
         r_state <= ~r_state;
         r_cnt   <= '0;
      end else begin
         r_cnt <= r_cnt + CW'(1);
      end
   end

   assign o_dist_state = r_state;

endmodule

// File: rtl/proximity_detector.sv
// Multi-side IR proximity front end: debounced side flags, rise pulse with
// retrigger lockout, triggering side index and saturating event counter.
module proximity_detector
   import proximity_pkg::*;
#(
   parameter  int NUM_SIDES        = DEF_NUM_SIDES,
   parameter  int SENSORS_PER_SIDE = DEF_SENSORS_PER_SIDE,
   parameter  int DEBOUNCE_CYCLES  = DEF_DEBOUNCE_CYCLES,
   parameter  int LOCKOUT_CYCLES   = DEF_LOCKOUT_CYCLES,
   parameter  int CNT_W            = DEF_CNT_W,
   localparam int SIDE_W           = width_for(NUM_SIDES)
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic [NUM_SIDES*SENSORS_PER_SIDE-1:0] DIS,
   input  logic                                  any_mode,
   input  logic                                  clear_count,
   output logic [NUM_SIDES-1:0]                  dist_state,
   output logic                                  proximity,
   output logic [SIDE_W-1:0]                     side_id,
   output logic                                  locked,
   output logic [CNT_W-1:0]                      event_count
);

   localparam int             LW      = width_for(LOCKOUT_CYCLES + 1);
   localparam logic [LW-1:0]  LOCK_LD = LW'(LOCKOUT_CYCLES);

   logic [NUM_SIDES-1:0] w_dist;
   logic [NUM_SIDES-1:0] r_dist_d;
   logic [NUM_SIDES-1:0] w_rise;
   logic [SIDE_W-1:0]    w_first;
   logic                 w_accept;
   logic [LW-1:0]        r_lock;
   logic                 r_prox;
   logic [SIDE_W-1:0]    r_side;
   logic [CNT_W-1:0]     r_cnt;

   for (genvar s = 0; s < NUM_SIDES; s++) begin : g_side
      side_debouncer #(
         .SENSORS         (SENSORS_PER_SIDE),
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_deb (
         .clk          (clk),
         .rst          (rst),
         .i_dis        (DIS[s*SENSORS_PER_SIDE +: SENSORS_PER_SIDE]),
         .i_any_mode   (any_mode),
         .o_dist_state (w_dist[s])
      );
   end

   assign w_rise   = w_dist & ~r_dist_d;
   assign w_accept = (|w_rise) && (r_lock == '0);

   // Lowest-index rising side wins
   always_comb begin
      w_first = '0;
      for (int s = NUM_SIDES - 1; s >= 0; s--) begin
         if (w_rise[s]) w_first = SIDE_W'(s);
      end
   end

   // Delayed flags, pulse, side capture and lockout countdown
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_dist_d <= '0;
         r_prox   <= 1'b0;
         r_side   <= '0;
         r_lock   <= '0;
      end else begin
         r_dist_d <= w_dist;
         r_prox   <= w_accept;
         if (w_accept) begin
            r_side <= w_first;
            r_lock <= LOCK_LD;
         end else if (r_lock != '0) begin
            r_lock <= r_lock - LW'(1);
         end
      end
   end

   // Saturating event counter; a same-cycle clear still counts the new pulse
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (clear_count) begin
         r_cnt <= w_accept ? CNT_W'(1) : '0;
      end else if (w_accept && (r_cnt != '1)) begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   assign dist_state  = w_dist;
   assign proximity   = r_prox;
   assign side_id     = r_side;
   assign locked      = (r_lock != '0);
   assign event_count = r_cnt;

endmodule

// File: tb/tb_proximity_detector.sv
// Scoreboard bench: stimulus queues expected pulses, monitor checks them.
module tb_proximity_detector;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] DIS;
   logic       any_mode;
   logic       clear_count;
   logic [1:0] dist_state;
   logic       proximity;
   logic [0:0] side_id;
   logic       locked;
   logic [3:0] event_count;

   int n_tests = 0;
   int n_fail  = 0;
   int exp_side[$];
   int exp_cnt[$];

   always #5 clk = ~clk;

   proximity_detector #(
      .DEBOUNCE_CYCLES (4),
      .LOCKOUT_CYCLES  (10),
      .CNT_W           (4)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .DIS         (DIS),
      .any_mode    (any_mode),
      .clear_count (clear_count),
      .dist_state  (dist_state),
      .proximity   (proximity),
      .side_id     (side_id),
      .locked      (locked),
      .event_count (event_count)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic expect_pulse(input int s, input int c);
      exp_side.push_back(s);
      exp_cnt.push_back(c);
   endtask

   // Monitor: every pulse must match the oldest queued expectation
   always @(negedge clk) begin : mon
      int s;
      int c;
      if (proximity === 1'b1) begin
         if (exp_side.size() == 0) begin
            chk("unexpected_pulse", 1, 0);
         end else begin
            s = exp_side.pop_front();
            c = exp_cnt.pop_front();
            chk("pulse_side_id", side_id, s);
            chk("pulse_event_count", event_count, c);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int w;
      rst = 1'b1; DIS = 4'b0000; any_mode = 1'b0; clear_count = 1'b0;
      tick(3);
      chk("rst_dist_state", dist_state, 0);
      chk("rst_proximity", proximity, 0);
      chk("rst_side_id", side_id, 0);
      chk("rst_locked", locked, 0);
      chk("rst_event_count", event_count, 0);
      rst = 1'b0;
      tick(2);

      // Side 0 detect, latency and lockout length
      expect_pulse(0, 1);
      DIS = 4'b0011;
      tick(5);
      chk("latency_early", dist_state, 0);
      tick(1);
      chk("latency_edge", dist_state, 1);
      chk("no_pulse_yet", proximity, 0);
      tick(1);
      chk("pulse_now", proximity, 1);
      chk("locked_start", locked, 1);
      tick(9);
      chk("locked_last", locked, 1);
      tick(1);
      chk("locked_end", locked, 0);
      DIS = 4'b0000;
      tick(12);
      chk("fall_no_pulse", dist_state, 0);

      // Glitch and mode switch
      DIS = 4'b1100;
      tick(3);
      DIS = 4'b0000;
      tick(10);
      chk("glitch_filtered", dist_state, 0);
      DIS = 4'b0100;
      tick(10);
      chk("all_mode_partial", dist_state, 0);
      expect_pulse(1, 2);
      any_mode = 1'b1;
      tick(10);
      chk("any_mode_hit", dist_state, 2);
      DIS = 4'b0000; any_mode = 1'b0;
      tick(20);

      // Simultaneous rise, then a side-0 re-rise inside lockout
      expect_pulse(0, 3);
      DIS = 4'b1111;
      tick(4);
      DIS = 4'b1100;
      tick(2);
      chk("simul_both", dist_state, 3);
      tick(3);
      DIS = 4'b1111;
      tick(1);
      chk("side0_fell", dist_state, 2);
      chk("side0_fell_locked", locked, 1);
      tick(5);
      chk("side0_rose", dist_state, 3);
      chk("side0_rose_locked", locked, 1);
      tick(10);
      chk("dropped_rise_count", event_count, 3);
      DIS = 4'b0000;
      tick(20);

      // Saturation: pulses 4..17
      for (int i = 4; i <= 17; i++) begin
         expect_pulse(0, (i > 15) ? 15 : i);
         DIS = 4'b0011;
         tick(12);
         DIS = 4'b0000;
         tick(12);
         if (i == 15) chk("sat_reach", event_count, 15);
      end
      chk("sat_hold", event_count, 15);

      // Clear in the same cycle as an accepted pulse
      DIS = 4'b0011;
      w = 0;
      while (dist_state[0] !== 1'b1 && w < 20) begin
         tick(1);
         w++;
      end
      chk("clr_wait_bound", (w < 20) ? 1 : 0, 1);
      expect_pulse(0, 1);
      clear_count = 1'b1;
      tick(1);
      clear_count = 1'b0;
      chk("clear_with_pulse", event_count, 1);
      DIS = 4'b0000;
      tick(20);
      clear_count = 1'b1;
      tick(1);
      clear_count = 1'b0;
      chk("clear_alone", event_count, 0);

      // Async reset mid-lockout
      expect_pulse(0, 1);
      DIS = 4'b0011;
      tick(8);
      chk("pre_reset_locked", locked, 1);
      #2 rst = 1'b1;
      #1;
      chk("async_dist_state", dist_state, 0);
      chk("async_proximity", proximity, 0);
      chk("async_side_id", side_id, 0);
      chk("async_locked", locked, 0);
      chk("async_event_count", event_count, 0);
      tick(2);
      rst = 1'b0;
      expect_pulse(0, 1);
      tick(6);
      chk("post_reset_no_pulse", proximity, 0);
      tick(1);
      chk("post_reset_pulse", proximity, 1);
      chk("post_reset_count", event_count, 1);
      tick(15);
      chk("pending_pulses", exp_side.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
